// File: rtl/rib_sram_responder_if.sv
// RIB data-bus port between the core's ex-stage memory master and a word-wide SRAM responder.
interface rib_sram_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, addr, we, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, addr, we, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/rib_sram_responder.sv
// Word-wide SRAM responder on the RIB data bus: window decode, programmable wait states,
// one-cycle ready pulse, and an error pulse for out-of-window or misaligned accesses.
module rib_sram_responder #(
  parameter int unsigned Depth      = 4096,
  parameter logic [31:0] BaseAddr   = 32'h1000_0000,
  parameter int unsigned WaitStates = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rib_sram_responder_if.slave  bus
);

  localparam int unsigned IdxW        = $clog2(Depth);
  localparam logic [32:0] WindowBytes = 33'(Depth) * 33'd4;
  localparam logic [3:0]  CntInit     = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;
  localparam bit          NoWait      = (WaitStates == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] data_q;
  logic        ready_q;
  logic        err_q;
  logic        busy_q;

  logic [31:0] mem [Depth];

  logic            accept;
  logic            resp_entry;
  logic [31:0]     src_addr;
  logic [31:0]     src_wdata;
  logic            src_we;
  logic [31:0]     offset;
  logic            src_hit;
  logic [IdxW-1:0] src_idx;

  // With zero wait states the access completes on the acceptance edge, so decode must look
  // at the live bus rather than the (not yet loaded) latched copy.
  always_comb begin
    accept     = (state_q == StIdle) && bus.req;
    src_addr   = accept ? bus.addr  : addr_q;
    src_wdata  = accept ? bus.wdata : wdata_q;
    src_we     = accept ? bus.we    : we_q;
    offset     = src_addr - BaseAddr;
    src_hit    = ({1'b0, offset} < WindowBytes) && (src_addr[1:0] == 2'b00);
    src_idx    = IdxW'(offset >> 2);
    resp_entry = (accept && NoWait) || ((state_q == StWait) && (cnt_q == 4'd0));
  end

  // Array is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && resp_entry && src_hit && src_we) begin
      mem[src_idx] <= src_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
            busy_q  <= 1'b1;
            if (NoWait) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase

      // Response is registered on the edge into StResp so ready/err/data line up.
      if (resp_entry) begin
        ready_q <= 1'b1;
        err_q   <= !src_hit;
        if (!src_hit) begin
          data_q <= 32'd0;
        end else if (!src_we) begin
          data_q <= mem[src_idx];
        end
      end
    end
  end

  assign bus.rdata = data_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule
